// File: rtl/sc_lane_pkg.sv
// Shared definitions for the vehicle-lane driver: FSM encoding, level width,
// minimum tick period and the default per-level load patterns.
package sc_lane_pkg;

  localparam int LEVEL_W    = 2;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } lane_state_e;

  localparam logic [7:0] PATTERN_L0_DEF = 8'h81;
  localparam logic [7:0] PATTERN_L1_DEF = 8'h91;
  localparam logic [7:0] PATTERN_L2_DEF = 8'hA5;
  localparam logic [7:0] PATTERN_L3_DEF = 8'hDB;

endpackage

// File: rtl/sc_lane_driver_if.sv
// Control/lane bus between the game FSM (master) and one lane driver (slave).
// SC_LANE_DRIVER_STEP_CNT_EN adds the STEP/REV revolution outputs.
interface sc_lane_driver_if #(
  parameter int DATAWIDTH_BUS = 8
);
  import sc_lane_pkg::*;

  logic                     SC_LDRV_START_IN;
  logic [LEVEL_W-1:0]       SC_LDRV_LEVEL_IN;
  logic                     SC_LDRV_STOP_IN;
  logic                     SC_LDRV_PAUSE_IN;
  logic                     SC_LDRV_LOAD_OUT;
  logic [DATAWIDTH_BUS-1:0] SC_LDRV_PATTERN_OUT;
  logic                     SC_LDRV_VEL_OUT;
  logic                     SC_LDRV_BUSY_OUT;

`ifdef SC_LANE_DRIVER_STEP_CNT_EN
  logic [$clog2(DATAWIDTH_BUS)-1:0] SC_LDRV_STEP_OUT;
  logic                             SC_LDRV_REV_OUT;

  modport master (
    output SC_LDRV_START_IN, SC_LDRV_LEVEL_IN, SC_LDRV_STOP_IN, SC_LDRV_PAUSE_IN,
    input  SC_LDRV_LOAD_OUT, SC_LDRV_PATTERN_OUT, SC_LDRV_VEL_OUT, SC_LDRV_BUSY_OUT,
    input  SC_LDRV_STEP_OUT, SC_LDRV_REV_OUT
  );

  modport slave (
    input  SC_LDRV_START_IN, SC_LDRV_LEVEL_IN, SC_LDRV_STOP_IN, SC_LDRV_PAUSE_IN,
    output SC_LDRV_LOAD_OUT, SC_LDRV_PATTERN_OUT, SC_LDRV_VEL_OUT, SC_LDRV_BUSY_OUT,
    output SC_LDRV_STEP_OUT, SC_LDRV_REV_OUT
  );
`else
  modport master (
    output SC_LDRV_START_IN, SC_LDRV_LEVEL_IN, SC_LDRV_STOP_IN, SC_LDRV_PAUSE_IN,
    input  SC_LDRV_LOAD_OUT, SC_LDRV_PATTERN_OUT, SC_LDRV_VEL_OUT, SC_LDRV_BUSY_OUT
  );

  modport slave (
    input  SC_LDRV_START_IN, SC_LDRV_LEVEL_IN, SC_LDRV_STOP_IN, SC_LDRV_PAUSE_IN,
    output SC_LDRV_LOAD_OUT, SC_LDRV_PATTERN_OUT, SC_LDRV_VEL_OUT, SC_LDRV_BUSY_OUT
  );
`endif

endinterface

// File: rtl/sc_lane_prescaler.sv
// Tick prescaler: counts while enabled, wraps at period-1 and registers a one-cycle tick.
// With SC_LANE_DRIVER_STEP_CNT_EN the wrap strobe is exported for the step counter.
module sc_lane_prescaler #(
  parameter int PRESCALE_WIDTH = 20
) (
  input  logic                      SC_REGDD_CLOCK,
  input  logic                      SC_REGDD_RESET,
  input  logic                      i_clear,
  input  logic                      i_enable,
  input  logic [PRESCALE_WIDTH-1:0] i_period,
  output logic                      o_tick
`ifdef SC_LANE_DRIVER_STEP_CNT_EN
  ,
  output logic                      o_tick_set
`endif
);

  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic                      r_tick;
  logic                      w_last;
  logic                      w_tick_set;

  // >= rather than == keeps the counter bounded even if the period ever shrinks mid-count.
  assign w_last     = (r_cnt >= i_period - PRESCALE_WIDTH'(1));
  assign w_tick_set = i_enable && !i_clear && w_last;

  // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
  always_ff @(posedge SC_REGDD_CLOCK or posedge SC_REGDD_RESET) begin
    if (SC_REGDD_RESET) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick_set;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_enable) begin
        r_cnt <= w_last ? '0 : r_cnt + PRESCALE_WIDTH'(1);
      end
    end
  end

  assign o_tick = r_tick;
`ifdef SC_LANE_DRIVER_STEP_CNT_EN
  assign o_tick_set = w_tick_set;
`endif

endmodule

// File: rtl/sc_lane_driver.sv
// Lane driver: on START latches a level, pulses LOAD with that level's pattern, then emits VEL ticks.
// SC_LANE_DRIVER_STEP_CNT_EN adds the STEP (VEL count mod lane width) and REV outputs.
module sc_lane_driver
  import sc_lane_pkg::*;
#(
  parameter int                        DATAWIDTH_BUS  = 8,
  parameter int                        PRESCALE_WIDTH = 20,
  parameter logic [PRESCALE_WIDTH-1:0] PERIOD_BASE    = 20'd800000,
  parameter logic [DATAWIDTH_BUS-1:0]  PATTERN_L0     = PATTERN_L0_DEF,
  parameter logic [DATAWIDTH_BUS-1:0]  PATTERN_L1     = PATTERN_L1_DEF,
  parameter logic [DATAWIDTH_BUS-1:0]  PATTERN_L2     = PATTERN_L2_DEF,
  parameter logic [DATAWIDTH_BUS-1:0]  PATTERN_L3     = PATTERN_L3_DEF
) (
  input  logic            SC_REGDD_CLOCK,
  input  logic            SC_REGDD_RESET,
  sc_lane_driver_if.slave lane_if
);

  localparam logic [PRESCALE_WIDTH-1:0] MIN_PERIOD_W = PRESCALE_WIDTH'(MIN_PERIOD);

  lane_state_e               r_state;
  lane_state_e               w_state_nxt;
  logic [LEVEL_W-1:0]        r_level;
  logic [DATAWIDTH_BUS-1:0]  r_pattern;
  logic [DATAWIDTH_BUS-1:0]  w_pattern_sel;
  logic                      r_load;
  logic                      r_busy;
  logic                      w_start_acc;
  logic                      w_cnt_clear;
  logic                      w_cnt_en;
  logic                      w_vel;
  logic [PRESCALE_WIDTH-1:0] w_period_raw;
  logic [PRESCALE_WIDTH-1:0] w_period;

  // STOP outranks START, which outranks PAUSE; a dropped START latches nothing.
  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    if (lane_if.SC_LDRV_STOP_IN) begin
      w_state_nxt = ST_IDLE;
    end else if (lane_if.SC_LDRV_START_IN) begin
      w_state_nxt = ST_LOAD;
      w_start_acc = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE:         w_state_nxt = ST_IDLE;
        ST_LOAD:         w_state_nxt = ST_RUN;
        ST_RUN, ST_HOLD: w_state_nxt = lane_if.SC_LDRV_PAUSE_IN ? ST_HOLD : ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_pattern_sel = PATTERN_L0;
    case (lane_if.SC_LDRV_LEVEL_IN)
      2'd1:    w_pattern_sel = PATTERN_L1;
      2'd2:    w_pattern_sel = PATTERN_L2;
      2'd3:    w_pattern_sel = PATTERN_L3;
      default: w_pattern_sel = PATTERN_L0;
    endcase
  end

  always_ff @(posedge SC_REGDD_CLOCK or posedge SC_REGDD_RESET) begin
    if (SC_REGDD_RESET) begin
      r_state   <= ST_IDLE;
      r_level   <= '0;
      r_pattern <= '0;
      r_load    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_load  <= (w_state_nxt == ST_LOAD);
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_start_acc) begin
        r_level   <= lane_if.SC_LDRV_LEVEL_IN;
        r_pattern <= w_pattern_sel;
      end
    end
  end

  // Prescaler follows the next state, so its count lines up with the state register:
  // the LOAD->RUN edge is the first counted clock and VEL lands exactly one period after LOAD.
  assign w_cnt_en    = (w_state_nxt == ST_RUN);
  assign w_cnt_clear = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_IDLE);

  assign w_period_raw = PERIOD_BASE >> r_level;
  assign w_period     = (w_period_raw < MIN_PERIOD_W) ? MIN_PERIOD_W : w_period_raw;

`ifdef SC_LANE_DRIVER_STEP_CNT_EN
  localparam int STEP_W = $clog2(DATAWIDTH_BUS);

  logic              w_tick_set;
  logic [STEP_W-1:0] r_step;
  logic              r_rev;
  logic              w_step_last;

  sc_lane_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .SC_REGDD_CLOCK (SC_REGDD_CLOCK),
    .SC_REGDD_RESET (SC_REGDD_RESET),
    .i_clear        (w_cnt_clear),
    .i_enable       (w_cnt_en),
    .i_period       (w_period),
    .o_tick         (w_vel),
    .o_tick_set     (w_tick_set)
  );

  assign w_step_last = (r_step == STEP_W'(DATAWIDTH_BUS - 1));

  // Updated on the same edge that raises VEL, so STEP and REV are coincident with it.
  always_ff @(posedge SC_REGDD_CLOCK or posedge SC_REGDD_RESET) begin
    if (SC_REGDD_RESET) begin
      r_step <= '0;
      r_rev  <= 1'b0;
    end else if (w_cnt_clear) begin
      r_step <= '0;
      r_rev  <= 1'b0;
    end else begin
      r_rev <= w_tick_set && w_step_last;
      if (w_tick_set) begin
        r_step <= w_step_last ? '0 : r_step + STEP_W'(1);
      end
    end
  end

  assign lane_if.SC_LDRV_STEP_OUT = r_step;
  assign lane_if.SC_LDRV_REV_OUT  = r_rev;
`else
  sc_lane_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .SC_REGDD_CLOCK (SC_REGDD_CLOCK),
    .SC_REGDD_RESET (SC_REGDD_RESET),
    .i_clear        (w_cnt_clear),
    .i_enable       (w_cnt_en),
    .i_period       (w_period),
    .o_tick         (w_vel)
  );
`endif

  assign lane_if.SC_LDRV_LOAD_OUT    = r_load;
  assign lane_if.SC_LDRV_PATTERN_OUT = r_pattern;
  assign lane_if.SC_LDRV_VEL_OUT     = w_vel;
  assign lane_if.SC_LDRV_BUSY_OUT    = r_busy;

endmodule

// File: tb/tb_sc_lane_driver.sv
// Scoreboard bench for sc_lane_driver: stimulus queues expected LOAD/VEL events, a monitor
// pops and compares each event the DUTs present. dut0 uses PERIOD_BASE=16, dut1 PERIOD_BASE=4.
module tb_sc_lane_driver;

  typedef struct {
    int         cyc;
    bit         is_load;
    logic [7:0] pat;
    int         step;
    bit         rev;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  logic [1:0] start_r = '0;
  logic [1:0] stop_r  = '0;
  logic [1:0] pause_r = '0;
  logic [1:0] level_r [2];

  exp_t exp_q [2][$];
  exp_t e_mon;

  sc_lane_driver_if #(.DATAWIDTH_BUS(8)) if0 ();
  sc_lane_driver_if #(.DATAWIDTH_BUS(8)) if1 ();

  assign if0.SC_LDRV_START_IN = start_r[0];
  assign if0.SC_LDRV_STOP_IN  = stop_r[0];
  assign if0.SC_LDRV_PAUSE_IN = pause_r[0];
  assign if0.SC_LDRV_LEVEL_IN = level_r[0];
  assign if1.SC_LDRV_START_IN = start_r[1];
  assign if1.SC_LDRV_STOP_IN  = stop_r[1];
  assign if1.SC_LDRV_PAUSE_IN = pause_r[1];
  assign if1.SC_LDRV_LEVEL_IN = level_r[1];

  sc_lane_driver #(
    .DATAWIDTH_BUS  (8),
    .PRESCALE_WIDTH (20),
    .PERIOD_BASE    (20'd16)
  ) dut0 (
    .SC_REGDD_CLOCK (clk),
    .SC_REGDD_RESET (rst),
    .lane_if        (if0)
  );

  sc_lane_driver #(
    .DATAWIDTH_BUS  (8),
    .PRESCALE_WIDTH (20),
    .PERIOD_BASE    (20'd4)
  ) dut1 (
    .SC_REGDD_CLOCK (clk),
    .SC_REGDD_RESET (rst),
    .lane_if        (if1)
  );

  logic [1:0] ev_load;
  logic [1:0] ev_vel;
  logic [7:0] ev_pat [2];
  assign ev_load   = {if1.SC_LDRV_LOAD_OUT, if0.SC_LDRV_LOAD_OUT};
  assign ev_vel    = {if1.SC_LDRV_VEL_OUT, if0.SC_LDRV_VEL_OUT};
  assign ev_pat[0] = if0.SC_LDRV_PATTERN_OUT;
  assign ev_pat[1] = if1.SC_LDRV_PATTERN_OUT;
`ifdef SC_LANE_DRIVER_STEP_CNT_EN
  logic [2:0] ev_step [2];
  logic [1:0] ev_rev;
  assign ev_step[0] = if0.SC_LDRV_STEP_OUT;
  assign ev_step[1] = if1.SC_LDRV_STEP_OUT;
  assign ev_rev     = {if1.SC_LDRV_REV_OUT, if0.SC_LDRV_REV_OUT};
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Monitor: every LOAD or VEL a DUT presents must match the head of its expectation queue.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ev_load[d] || ev_vel[d]) begin
        n_vec++;
        if (exp_q[d].size() == 0) begin
          n_miss++;
          $display("FAIL dut%0d_unexpected: load=%0b vel=%0b pat=%02h at cycle %0d, required no event",
                   d, ev_load[d], ev_vel[d], ev_pat[d], cyc);
        end else begin
          bit bad;
          e_mon = exp_q[d].pop_front();
          bad = (cyc != e_mon.cyc) || (ev_load[d] !== e_mon.is_load) ||
                (ev_vel[d] !== !e_mon.is_load) || (ev_pat[d] !== e_mon.pat);
`ifdef SC_LANE_DRIVER_STEP_CNT_EN
          bad = bad || (ev_step[d] !== 3'(e_mon.step)) || (ev_rev[d] !== e_mon.rev);
          if (bad)
            $display("FAIL dut%0d_event: cycle=%0d load=%0b vel=%0b pat=%02h step=%0d rev=%0b, required cycle=%0d load=%0b pat=%02h step=%0d rev=%0b",
                     d, cyc, ev_load[d], ev_vel[d], ev_pat[d], ev_step[d], ev_rev[d],
                     e_mon.cyc, e_mon.is_load, e_mon.pat, e_mon.step, e_mon.rev);
`else
          if (bad)
            $display("FAIL dut%0d_event: cycle=%0d load=%0b vel=%0b pat=%02h, required cycle=%0d load=%0b pat=%02h",
                     d, cyc, ev_load[d], ev_vel[d], ev_pat[d], e_mon.cyc, e_mon.is_load, e_mon.pat);
`endif
          if (bad) n_miss++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input int d, input int c, input bit is_load, input logic [7:0] pat, input int step);
    exp_t e;
    e.cyc     = c;
    e.is_load = is_load;
    e.pat     = pat;
    e.step    = step;
    e.rev     = !is_load && (step == 0);
    exp_q[d].push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the LOAD cycle with its cycle number.
  task automatic do_start(input int d, input logic [1:0] lvl, input logic [7:0] pat,
                          input int period, input int nvel, output int l_cyc);
    start_r[d] = 1'b1;
    level_r[d] = lvl;
    l_cyc = cyc + 1;
    push(d, l_cyc, 1'b1, pat, 0);
    for (int k = 1; k <= nvel; k++) push(d, l_cyc + k * period, 1'b0, pat, k % 8);
    @(negedge clk);
    start_r[d] = 1'b0;
  endtask

  task automatic do_stop(input int d);
    stop_r[d] = 1'b1;
    @(negedge clk);
    stop_r[d] = 1'b0;
  endtask

  initial begin
    int l0;
    int l2;
    level_r[0] = 2'd0;
    level_r[1] = 2'd0;

    // Reset values, then 100 idle cycles with no events.
    repeat (3) @(negedge clk);
    check("rst_load", 32'(if0.SC_LDRV_LOAD_OUT), 0);
    check("rst_vel", 32'(if0.SC_LDRV_VEL_OUT), 0);
    check("rst_busy", 32'(if0.SC_LDRV_BUSY_OUT), 0);
    check("rst_pattern", 32'(if0.SC_LDRV_PATTERN_OUT), 32'h00);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_busy", 32'(if0.SC_LDRV_BUSY_OUT), 0);

    // Level 0: period 16; a LEVEL change without START must not matter.
    do_start(0, 2'd0, 8'h81, 16, 3, l0);
    check("l0_busy_load", 32'(if0.SC_LDRV_BUSY_OUT), 1);
    level_r[0] = 2'd3;
    wait_until(l0 + 30);
    check("l0_busy_run", 32'(if0.SC_LDRV_BUSY_OUT), 1);
    wait_until(l0 + 50);
    do_stop(0);
    check("stop_busy", 32'(if0.SC_LDRV_BUSY_OUT), 0);
    check("stop_pattern_held", 32'(if0.SC_LDRV_PATTERN_OUT), 32'h81);

    // Level 3: period 2.
    repeat (5) @(negedge clk);
    do_start(0, 2'd3, 8'hDB, 2, 5, l0);
    wait_until(l0 + 11);
    do_stop(0);

    // PERIOD_BASE=4 at level 3 clamps to period 2.
    do_start(1, 2'd3, 8'hDB, 2, 4, l0);
    wait_until(l0 + 9);
    do_stop(1);
    repeat (5) @(negedge clk);

    // Pause 10 cycles at count 5: next VEL 11 cycles after PAUSE falls.
    do_start(0, 2'd0, 8'h81, 16, 0, l0);
    push(0, l0 + 26, 1'b0, 8'h81, 1);
    push(0, l0 + 42, 1'b0, 8'h81, 2);
    wait_until(l0 + 5);
    pause_r[0] = 1'b1;
    wait_until(l0 + 10);
    check("hold_busy", 32'(if0.SC_LDRV_BUSY_OUT), 1);
    wait_until(l0 + 15);
    pause_r[0] = 1'b0;
    wait_until(l0 + 45);
    do_stop(0);

    // Restart mid-RUN at level 2: new LOAD, pattern A5, period 4.
    do_start(0, 2'd0, 8'h81, 16, 0, l0);
    wait_until(l0 + 10);
    do_start(0, 2'd2, 8'hA5, 4, 3, l2);
    wait_until(l2 + 13);
    do_stop(0);

    // START+STOP together: STOP wins, no LOAD, pattern not relatched.
    do_start(0, 2'd1, 8'h91, 8, 1, l0);
    wait_until(l0 + 10);
    start_r[0] = 1'b1;
    stop_r[0]  = 1'b1;
    level_r[0] = 2'd2;
    @(negedge clk);
    start_r[0] = 1'b0;
    stop_r[0]  = 1'b0;
    repeat (30) @(negedge clk);
    check("conflict_busy", 32'(if0.SC_LDRV_BUSY_OUT), 0);
    check("conflict_pattern", 32'(if0.SC_LDRV_PATTERN_OUT), 32'h91);

    // Reset mid-RUN: immediate reset values, no later VEL.
    do_start(0, 2'd3, 8'hDB, 2, 2, l0);
    wait_until(l0 + 5);
    rst = 1'b1;
    #1;
    check("midrst_vel", 32'(if0.SC_LDRV_VEL_OUT), 0);
    check("midrst_busy", 32'(if0.SC_LDRV_BUSY_OUT), 0);
    check("midrst_pattern", 32'(if0.SC_LDRV_PATTERN_OUT), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_idle_busy", 32'(if0.SC_LDRV_BUSY_OUT), 0);

`ifdef SC_LANE_DRIVER_STEP_CNT_EN
    // Nine VELs at period 2: STEP 1..7,0,1 with REV on the 8th; STOP clears STEP.
    do_start(0, 2'd3, 8'hDB, 2, 9, l0);
    wait_until(l0 + 19);
    do_stop(0);
    check("stop_step", 32'(if0.SC_LDRV_STEP_OUT), 0);
    check("stop_rev", 32'(if0.SC_LDRV_REV_OUT), 0);
`endif

    repeat (5) @(negedge clk);
    check("dut0_pending_events", 32'(exp_q[0].size()), 0);
    check("dut1_pending_events", 32'(exp_q[1].size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
